// File: rtl/bm_rng_pkg.sv
// bm_rng_pkg: shared types for the Box-Muller RNG output path.
//   SAMPLE_W   : width of one RNG sample
//   bm_pair_t  : one {x0, x1} pair as produced by the RNG core
//   bm_phase_t : output-stage phase (EMPTY, X0, X1)
package bm_rng_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] x0;
        logic [SAMPLE_W-1:0] x1;
    } bm_pair_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        X0    = 2'd1,
        X1    = 2'd2
    } bm_phase_t;

endpackage

// File: rtl/bm_pair_fifo.sv
// bm_pair_fifo: DEPTH-entry synchronous FIFO of bm_pair_t.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (pointers/level)
//   push, wdata  write one pair (caller guarantees !full or a same-cycle pop)
//   pop, rdata   rdata is the current head; pop advances it (caller guarantees !empty)
//   full, empty  status flags
//   level        number of pairs held
module bm_pair_fifo
    import bm_rng_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  bm_pair_t                 wdata,
    input  logic                     pop,
    output bm_pair_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    bm_pair_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;

    // Storage carries no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/bm_sample_sink.sv
// bm_sample_sink: receives {x0,x1} pairs from the Box-Muller RNG core (no
// backpressure), buffers them in a FIFO and emits a single 16-bit sample
// stream with valid/ready. Pairs arriving while the FIFO is full are dropped
// and counted.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   en                  accept pairs when 1; in_valid ignored when 0
//   in_valid,x0_in,x1_in  input pair
//   clear               sync clear of drop_cnt/overflow/stats
//   out_data,out_sel    current sample and which half of the pair it is
//   out_valid,out_ready output handshake
//   level               pairs held in the FIFO (output stage excluded)
//   drop_cnt,overflow   saturating drop counter, sticky drop flag
//   stat_cnt,stat_sum   emitted-sample count and signed sum
// Configuration: define BM_SINK_STATS_EN to build the stats counters;
// otherwise stat_cnt/stat_sum are tied to zero.
module bm_sample_sink
    import bm_rng_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [SAMPLE_W-1:0]      x0_in,
    input  logic [SAMPLE_W-1:0]      x1_in,
    input  logic                     clear,
    output logic [SAMPLE_W-1:0]      out_data,
    output logic                     out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    output logic [31:0]              stat_cnt,
    output logic [31:0]              stat_sum
);

    bm_phase_t state, state_nxt;
    bm_pair_t  pair_q;
    bm_pair_t  head;
    logic      fifo_full, fifo_empty;
    logic      pop;
    logic      push_req, accept, drop;

    // A full FIFO still takes a pair when the output stage pops in the same cycle.
    assign push_req = en & in_valid;
    assign accept   = push_req & (~fifo_full | pop);
    assign drop     = push_req & ~accept;

    bm_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata ('{x0: x0_in, x1: x1_in}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Output phase FSM. X1 refills straight from the FIFO on its handshake so
    // back-to-back pairs stream without a bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sel   = 1'b0;
        case (state)
            EMPTY: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = X0;
                end
            end
            X0: begin
                out_valid = 1'b1;
                out_data  = pair_q.x0;
                if (out_ready) state_nxt = X1;
            end
            X1: begin
                out_valid = 1'b1;
                out_data  = pair_q.x1;
                out_sel   = 1'b1;
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = X0;
                    end else begin
                        state_nxt = EMPTY;
                    end
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    pair_q <= '0;
        else if (pop) pair_q <= head;
    end

    // clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

`ifdef BM_SINK_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_cnt <= '0;
            stat_sum <= '0;
        end else if (clear) begin
            stat_cnt <= '0;
            stat_sum <= '0;
        end else if (out_valid && out_ready) begin
            stat_cnt <= stat_cnt + 32'd1;
            stat_sum <= stat_sum + {{(32-SAMPLE_W){out_data[SAMPLE_W-1]}}, out_data};
        end
    end
`else
    assign stat_cnt = '0;
    assign stat_sum = '0;
`endif

endmodule

// File: tb/tb_bm_sample_sink.sv
// Bench for bm_sample_sink: directed table, hand sequences for overflow,
// full-with-pop, enable/reset and stats, then randomized traffic against a
// queue-based reference model. Uses a 4-bit drop counter so saturation occurs.
module tb_bm_sample_sink;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             en, in_valid, clear, out_ready;
    logic [15:0]      x0_in, x1_in;
    logic [15:0]      out_data;
    logic             out_sel, out_valid, overflow;
    logic [LW-1:0]    level;
    logic [CNT_W-1:0] drop_cnt;
    logic [31:0]      stat_cnt, stat_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bm_sample_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
        .x0_in(x0_in), .x1_in(x1_in), .clear(clear),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .drop_cnt(drop_cnt),
        .overflow(overflow), .stat_cnt(stat_cnt), .stat_sum(stat_sum)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic e, input logic iv, input logic [15:0] a,
                          input logic [15:0] b, input logic rdy, input logic clr);
        en = e; in_valid = iv; x0_in = a; x1_in = b; out_ready = rdy; clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iv;
        logic [15:0] a, b;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_sel;
        int          e_level;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [15:0] a, logic [15:0] b, logic rdy,
                                logic ev, logic [15:0] ed, logic es, int el);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_sel = es; v.e_level = el;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // FIFO as queues of pairs; the output stage as a queue of the samples of
    // the current pair still to be handed over (2, 1 or none).
    logic [15:0]      m_fx0[$], m_fx1[$], m_st[$];
    int               m_drop;
    bit               m_ovf;
    logic [31:0]      m_cnt, m_sum;

    task automatic model_reset();
        m_fx0.delete(); m_fx1.delete(); m_st.delete();
        m_drop = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
    endtask

    task automatic model_step();
        bit hs, need, take, req, acc;
        logic [15:0] s;
        hs   = (m_st.size() != 0) && out_ready;
        // stage wants a new pair once its last sample leaves (or it is idle)
        need = (m_st.size() == 0) || (m_st.size() == 1 && hs);
        take = need && (m_fx0.size() != 0);
        req  = en && in_valid;
        acc  = req && (m_fx0.size() < DEPTH || take);
        if (hs) begin
            s = m_st.pop_front();
            m_cnt = m_cnt + 1;
            m_sum = m_sum + {{16{s[15]}}, s};
        end
        if (take) begin
            m_st.push_back(m_fx0.pop_front());
            m_st.push_back(m_fx1.pop_front());
        end
        if (acc) begin
            m_fx0.push_back(x0_in);
            m_fx1.push_back(x1_in);
        end
        if (clear) begin
            m_drop = 0; m_ovf = 0; m_cnt = 0; m_sum = 0;
        end else if (req && !acc) begin
            m_ovf = 1;
            if (m_drop < (1 << CNT_W) - 1) m_drop++;
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {16'b0, out_data}, 32'd0);
        chk("rst_sel", {31'b0, out_sel}, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_scnt", stat_cnt, 32'd0);
        chk("rst_ssum", stat_sum, 32'd0);
        do_reset();

        // Test 1: single pair, ready=1, out_valid 2 cycles after in_valid.
        vecs.push_back(mk(1, 16'h1234, 16'hFEDC, 1, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'h1234, 0, 0));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'hFEDC, 1, 0));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 0, 16'h0000, 0, 0));
        // Test 2: backpressure for 5 cycles, then order preserved.
        vecs.push_back(mk(1, 16'h1234, 16'hFEDC, 0, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(1, 16'h1111, 16'h2222, 0, 0, 16'h0000, 0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 16'h0, 16'h0, 0, 1, 16'h1234, 0, 1));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'h1234, 0, 1));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'hFEDC, 1, 1));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'h1111, 0, 0));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 1, 16'h2222, 1, 0));
        vecs.push_back(mk(0, 16'h0,    16'h0,    1, 0, 16'h0000, 0, 0));

        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].rdy, 1'b0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("tbl%0d_data", i), {16'b0, out_data}, {16'b0, vecs[i].e_data});
            chk($sformatf("tbl%0d_sel", i), {31'b0, out_sel}, {31'b0, vecs[i].e_sel});
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            tick();
        end

        // Test 3: overflow with the output stage stalled.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b1, 16'(i), 16'(i + 16'h100), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_drop", 32'(drop_cnt), 32'd3);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        chk("ovf_head", {16'b0, out_data}, 32'h0000);

        // Test 4: full FIFO, pop and push in the same cycle.
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();                                   // X0 -> X1, no pop
        set_in(1'b1, 1'b1, 16'h0AAA, 16'h0BBB, 1'b1, 1'b0);
        @(negedge clk);
        chk("fp_sel", {31'b0, out_sel}, 32'd1);
        tick();                                   // pop + push
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fp_level", 32'(level), 32'd8);
        chk("fp_drop", 32'(drop_cnt), 32'd3);
        chk("fp_data", {16'b0, out_data}, 32'h0001);
        set_in(1'b1, 1'b1, 16'h0, 16'h0, 1'b0, 1'b1);  // drop in clear cycle not counted
        tick();
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", {31'b0, overflow}, 32'd0);

        // Test 5: en=0 ignores in_valid; async reset mid-stream.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b1, 16'h5555, 16'h6666, 1'b0, 1'b0);
            tick();
        end
        @(negedge clk);
        chk("en0_level", 32'(level), 32'd0);
        chk("en0_drop", 32'(drop_cnt), 32'd0);
        chk("en0_valid", {31'b0, out_valid}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 16'(i + 7), 16'h0, 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_level", 32'(level), 32'd0);
        tick();
        reset = 1'b0;

        // Test 6: stats.
        do_reset();
        set_in(1'b1, 1'b1, 16'h0003, 16'hFFFF, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b1, 16'h0010, 16'h8000, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick();
`ifdef BM_SINK_STATS_EN
        chk("stat_cnt", stat_cnt, 32'd4);
        chk("stat_sum", stat_sum, 32'hFFFF8012);
        set_in(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1);
        tick();
        chk("stat_clr_cnt", stat_cnt, 32'd0);
        chk("stat_clr_sum", stat_sum, 32'd0);
`else
        chk("stat_cnt_off", stat_cnt, 32'd0);
        chk("stat_sum_off", stat_sum, 32'd0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
                   16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 59) == 0);
            @(negedge clk);
            chk("rnd_valid", {31'b0, out_valid}, {31'b0, m_st.size() != 0});
            if (m_st.size() != 0) begin
                chk("rnd_data", {16'b0, out_data}, {16'b0, m_st[0]});
                chk("rnd_sel", {31'b0, out_sel}, {31'b0, m_st.size() == 1});
            end
            chk("rnd_level", 32'(level), 32'(m_fx0.size()));
            chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
            chk("rnd_ovf", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef BM_SINK_STATS_EN
            chk("rnd_scnt", stat_cnt, m_cnt);
            chk("rnd_ssum", stat_sum, m_sum);
`endif
            model_step();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
